rbb_wr_arbiter: RTL

Round-robin write-back arbiter that shares a single host write-request channel between NUM_RBB result batch buffers. It grants one buffer at a time and streams all of that buffer's lines to the host. Each line is issued as a write to a ring of result slots in host memory, and each issued line is acknowledged back to the buffer. It sits between the PE-array result buffers and the host TX write port.

---
 rtl/rbb_wr_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/rbb_wr_arbiter.sv
// rbb_wr_arbiter: round-robin write-back arbiter streaming whole result batches from NUM_RBB buffers into a host slot ring
module rbb_wr_arbiter #(
  parameter int NUM_RBB = 4,
  parameter int RBB_ADDR_WIDTH = 8,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int HOST_ADDR_WIDTH = 32,
  parameter int SLOT_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                Enable,
  input  logic [HOST_ADDR_WIDTH-1:0]          ResBase,
  input  logic [NUM_RBB-1:0]                  ReqValid,
  input  logic [NUM_RBB*RBB_ADDR_WIDTH-1:0]   ReqLineIdx,
  input  logic [NUM_RBB*RBB_DATA_WIDTH-1:0]   RdDout,
  output logic [NUM_RBB-1:0]                  ReqAck,
  output logic                                WrReqValid,
  output logic [HOST_ADDR_WIDTH-1:0]          WrReqAddr,
  output logic [RBB_DATA_WIDTH-1:0]           WrReqData,
  input  logic                                WrReqAlmostFull,
  output logic                                BatchDone,
  output logic [$clog2(NUM_RBB)-1:0]          BatchSrc,
  output logic [31:0]                         BatchCount
);
  localparam int GW = $clog2(NUM_RBB);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2;
  logic [1:0] r_state;
  logic [GW-1:0] r_grant, r_last_grant, w_next, w_cand;
  logic [RBB_ADDR_WIDTH-1:0] r_line_cnt, w_line_idx;
  logic [RBB_DATA_WIDTH-1:0] w_line_data;
  logic [SLOT_WIDTH-1:0] r_slot_ptr;
  logic [HOST_ADDR_WIDTH-1:0] r_slot_addr;
  logic [31:0] r_batch_count;
  logic w_issue;
  always_comb begin
    w_next = r_last_grant;
    w_cand = r_last_grant;
    for (int k = NUM_RBB; k >= 1; k--) begin
      w_cand = GW'((int'(r_last_grant) + k) % NUM_RBB);
      w_next = ReqValid[w_cand] ? w_cand : w_next;
    end
  end
  assign w_line_idx = ReqLineIdx[r_grant*RBB_ADDR_WIDTH +: RBB_ADDR_WIDTH];
  assign w_line_data = RdDout[r_grant*RBB_DATA_WIDTH +: RBB_DATA_WIDTH];
  assign w_issue = (r_state == XFER) & ReqValid[r_grant] & ~WrReqAlmostFull;
  assign ReqAck = NUM_RBB'(w_issue) << r_grant;
  assign BatchDone = (r_state == DONE);
  assign BatchSrc = r_grant;
  assign BatchCount = r_batch_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last_grant <= GW'(NUM_RBB - 1);
      r_line_cnt <= '0;
      r_slot_ptr <= '0;
      r_slot_addr <= '0;
      r_batch_count <= '0;
      WrReqValid <= 1'b0;
      WrReqAddr <= '0;
      WrReqData <= '0;
    end else begin
      WrReqValid <= w_issue;
      if (w_issue) begin
        WrReqAddr <= r_slot_addr + HOST_ADDR_WIDTH'(w_line_idx);
        WrReqData <= w_line_data;
        r_line_cnt <= r_line_cnt + 1'b1;
        if (&r_line_cnt) r_state <= DONE;
      end
      if (r_state == IDLE && Enable && |ReqValid) begin
        r_state <= XFER;
        r_grant <= w_next;
        r_line_cnt <= '0;
        r_slot_addr <= ResBase + (HOST_ADDR_WIDTH'(r_slot_ptr) << RBB_ADDR_WIDTH);
      end
      if (r_state == DONE) begin
        r_state <= IDLE;
        r_batch_count <= r_batch_count + 32'd1;
        r_slot_ptr <= r_slot_ptr + 1'b1;
        r_last_grant <= r_grant;
      end
    end
  end
endmodule
